// File: rtl/lsu_mem_issue_if.sv
// lsu_mem_issue_if: bundles the load/store-queue pop handshake, the memory
// request/return port and the writeback result of lsu_mem_issue.
//   master : the issue unit (consumes queue entries, drives the memory port
//            and the writeback result)
//   slave  : its environment (queue, memory subunit, writeback path)
// Signal groups:
//   load_*  / store_* : queue-side requests and the load_pop / store_pop accepts
//   mem_*             : one-entry request register output, ack and read return
//   wb_*              : registered, extended load results
//   ls_idle           : nothing held in the request register, no loads reserved
interface lsu_mem_issue_if #(
    parameter int ID_W = 3
);
    logic            load_valid;
    logic [31:0]     load_addr;
    logic [2:0]      load_fn3;
    logic [ID_W-1:0] load_id;
    logic            load_pop;

    logic            store_valid;
    logic [31:0]     store_addr;
    logic [3:0]      store_be;
    logic [31:0]     store_data;
    logic            store_pop;

    logic            mem_req;
    logic            mem_rnw;
    logic [31:0]     mem_addr;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic            mem_ack;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;

    logic            wb_valid;
    logic [ID_W-1:0] wb_id;
    logic [31:0]     wb_data;
    logic            ls_idle;

    modport master (
        input  load_valid, load_addr, load_fn3, load_id,
        input  store_valid, store_addr, store_be, store_data,
        input  mem_ack, mem_rvalid, mem_rdata,
        output load_pop, store_pop,
        output mem_req, mem_rnw, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_id, wb_data, ls_idle
    );

    modport slave (
        output load_valid, load_addr, load_fn3, load_id,
        output store_valid, store_addr, store_be, store_data,
        output mem_ack, mem_rvalid, mem_rdata,
        input  load_pop, store_pop,
        input  mem_req, mem_rnw, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_id, wb_data, ls_idle
    );
endinterface

// File: rtl/lsu_mem_issue.sv
// lsu_mem_issue: consumer end of the load/store queue. Pops one request per
// cycle (loads first) into a one-entry request register held until mem_ack,
// tracks issued loads in order and returns sign/zero-extended load data with
// its instruction ID one cycle after mem_rvalid.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : lsu_mem_issue_if.master (queue pops, memory port, writeback, idle)
module lsu_mem_issue #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_issue_if.master   bus
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic            slot_free;
    logic            load_pop;
    logic            store_pop;
    logic [CNT_W-1:0] reserved;

    logic            req_q;
    logic            rnw_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [ID_W-1:0] id_q;
    logic [2:0]      fn3_q;
    logic [1:0]      lo_q;

    logic [ID_W-1:0] trk_id  [MAX_OUTSTANDING];
    logic [2:0]      trk_fn3 [MAX_OUTSTANDING];
    logic [1:0]      trk_lo  [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] trk_cnt;
    logic            trk_push;
    logic            trk_pop;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ext_data;

    logic            wb_valid_q;
    logic [ID_W-1:0] wb_id_q;
    logic [31:0]     wb_data_q;

    // The slot can take a new request in the same cycle its current one is acked.
    assign slot_free = ~req_q | bus.mem_ack;
    assign load_pop  = bus.load_valid & slot_free & (reserved < MAX_CNT);
    assign store_pop = bus.store_valid & slot_free & ~load_pop;

    assign trk_push = req_q & bus.mem_ack & rnw_q;
    // Returns with nothing tracked are protocol errors and are dropped.
    assign trk_pop  = bus.mem_rvalid & (trk_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            id_q    <= '0;
            fn3_q   <= '0;
            lo_q    <= '0;
        end else if (load_pop) begin
            req_q   <= 1'b1;
            rnw_q   <= 1'b1;
            addr_q  <= {bus.load_addr[31:2], 2'b00};
            be_q    <= 4'hF;
            wdata_q <= '0;
            id_q    <= bus.load_id;
            fn3_q   <= bus.load_fn3;
            lo_q    <= bus.load_addr[1:0];
        end else if (store_pop) begin
            req_q   <= 1'b1;
            rnw_q   <= 1'b0;
            addr_q  <= bus.store_addr;
            be_q    <= bus.store_be;
            wdata_q <= bus.store_data;
        end else if (bus.mem_ack) begin
            req_q   <= 1'b0;
        end
    end

    // Counts loads from pop until their data returns, so it also covers the
    // load sitting in the slot and bounds the tracker occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reserved <= '0;
        end else begin
            case ({load_pop, trk_pop})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: reserved <= reserved;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            trk_cnt <= '0;
        end else begin
            if (trk_push) wr_ptr <= wr_ptr + 1'b1;
            if (trk_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({trk_push, trk_pop})
                2'b10:   trk_cnt <= trk_cnt + 1'b1;
                2'b01:   trk_cnt <= trk_cnt - 1'b1;
                default: trk_cnt <= trk_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (trk_push) begin
            trk_id[wr_ptr]  <= id_q;
            trk_fn3[wr_ptr] <= fn3_q;
            trk_lo[wr_ptr]  <= lo_q;
        end
    end

    always_comb begin
        byte_sel = bus.mem_rdata[7:0];
        half_sel = bus.mem_rdata[15:0];
        ext_data = bus.mem_rdata;
        case (trk_lo[rd_ptr])
            2'd0:    byte_sel = bus.mem_rdata[7:0];
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        if (trk_lo[rd_ptr][1]) half_sel = bus.mem_rdata[31:16];
        case (trk_fn3[rd_ptr])
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_data = {24'b0, byte_sel};
            3'b101:  ext_data = {16'b0, half_sel};
            default: ext_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= trk_pop;
            if (trk_pop) begin
                wb_id_q   <= trk_id[rd_ptr];
                wb_data_q <= ext_data;
            end
        end
    end

    assign bus.load_pop  = load_pop;
    assign bus.store_pop = store_pop;
    assign bus.mem_req   = req_q;
    assign bus.mem_rnw   = rnw_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_id     = wb_id_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.ls_idle   = ~req_q & (reserved == '0);
endmodule

// File: tb/tb_lsu_mem_issue.sv
module tb_lsu_mem_issue;
    localparam int MAX  = 4;
    localparam int ID_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_issue_if #(.ID_W(ID_W)) bus ();

    lsu_mem_issue #(.MAX_OUTSTANDING(MAX), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic            rnw;
        logic [31:0]     addr;
        logic [3:0]      be;
        logic [31:0]     wdata;
        logic [ID_W-1:0] id;
        logic [2:0]      fn3;
    } req_t;

    // Reference model: request register contents, loads popped but not yet
    // returned, and an in-order queue of loads accepted by memory.
    bit              m_slot_v;
    req_t            m_slot;
    int              m_rsv;
    req_t            m_trk[$];
    bit              m_wb_v;
    logic [ID_W-1:0] m_wb_id;
    logic [31:0]     m_wb_data;

    function automatic logic [31:0] ref_ext(logic [31:0] d, logic [2:0] fn3, logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * int'(a))) & 32'hFF;
        h = (d >> (16 * (int'(a) / 2))) & 32'hFFFF;
        case (fn3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic bit exp_lp();
        return bus.load_valid && (!m_slot_v || bus.mem_ack) && (m_rsv < MAX);
    endfunction

    function automatic bit exp_sp();
        return bus.store_valid && (!m_slot_v || bus.mem_ack) && !exp_lp();
    endfunction

    task automatic set_idle();
        bus.load_valid  = 1'b0;
        bus.load_addr   = '0;
        bus.load_fn3    = '0;
        bus.load_id     = '0;
        bus.store_valid = 1'b0;
        bus.store_addr  = '0;
        bus.store_be    = '0;
        bus.store_data  = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic tick();
        bit   lp;
        bit   sp;
        req_t e;
        lp = exp_lp();
        sp = exp_sp();
        if (bus.mem_rvalid && m_trk.size() > 0) begin
            e         = m_trk.pop_front();
            m_wb_v    = 1'b1;
            m_wb_id   = e.id;
            m_wb_data = ref_ext(bus.mem_rdata, e.fn3, e.addr[1:0]);
            m_rsv--;
        end else begin
            m_wb_v = 1'b0;
        end
        if (m_slot_v && bus.mem_ack && m_slot.rnw) m_trk.push_back(m_slot);
        if (lp) begin
            m_slot_v       = 1'b1;
            m_slot.rnw     = 1'b1;
            m_slot.addr    = bus.load_addr;
            m_slot.be      = 4'hF;
            m_slot.wdata   = '0;
            m_slot.id      = bus.load_id;
            m_slot.fn3     = bus.load_fn3;
            m_rsv++;
        end else if (sp) begin
            m_slot_v       = 1'b1;
            m_slot.rnw     = 1'b0;
            m_slot.addr    = bus.store_addr;
            m_slot.be      = bus.store_be;
            m_slot.wdata   = bus.store_data;
            m_slot.id      = '0;
            m_slot.fn3     = '0;
        end else if (bus.mem_ack) begin
            m_slot_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_idle();
        m_slot_v  = 1'b0;
        m_rsv     = 0;
        m_trk.delete();
        m_wb_v    = 1'b0;
        m_wb_id   = '0;
        m_wb_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(logic [31:0] a, logic [2:0] f, logic [ID_W-1:0] id);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_fn3   = f;
        bus.load_id    = id;
        bus.mem_ack    = 1'b0;
        tick();
        bus.load_valid = 1'b0;
        bus.mem_ack    = 1'b1;
        tick();
        bus.mem_ack    = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < MAX + 1 && m_trk.size() > 0; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            tick();
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_id !== m_wb_id || bus.wb_data !== m_wb_data) begin
                failures++;
                $display("FAIL drain_wb: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h",
                         bus.wb_valid, bus.wb_id, bus.wb_data, m_wb_id, m_wb_data);
            end
        end
        bus.mem_rvalid = 1'b0;
        tick();
        checks++;
        if (bus.ls_idle !== 1'b1) begin
            failures++;
            $display("FAIL drain_idle: got ls_idle=%b, want 1", bus.ls_idle);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.mem_req, bus.wb_valid, bus.load_pop, bus.store_pop} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got req/wbv/lp/sp=%b, want 0000",
                     {bus.mem_req, bus.wb_valid, bus.load_pop, bus.store_pop});
        end
        checks++;
        if (bus.ls_idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got %b, want 1", bus.ls_idle);
        end
        checks++;
        if ({bus.mem_rnw, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_payload: got rnw=%b addr=%h be=%h wdata=%h, want all 0",
                     bus.mem_rnw, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        checks++;
        if (bus.wb_id !== '0 || bus.wb_data !== '0) begin
            failures++;
            $display("FAIL reset_wb: got id=%0d data=%h, want 0", bus.wb_id, bus.wb_data);
        end
    endtask

    task automatic test_load_priority();
        bus.load_valid  = 1'b1;
        bus.load_addr   = 32'h0000_2005;
        bus.load_fn3    = 3'b010;
        bus.load_id     = 3'd5;
        bus.store_valid = 1'b1;
        bus.store_addr  = 32'h0000_3000;
        bus.store_be    = 4'h3;
        bus.store_data  = 32'hAABB_CCDD;
        #1;
        checks++;
        if (bus.load_pop !== 1'b1 || bus.store_pop !== 1'b0) begin
            failures++;
            $display("FAIL prio_pop: got lp=%b sp=%b, want lp=1 sp=0", bus.load_pop, bus.store_pop);
        end
        tick();
        bus.load_valid = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_rnw !== 1'b1 || bus.mem_be !== 4'hF || bus.mem_addr !== 32'h0000_2004) begin
            failures++;
            $display("FAIL prio_req: got req=%b rnw=%b be=%h addr=%h, want 1 1 f 00002004",
                     bus.mem_req, bus.mem_rnw, bus.mem_be, bus.mem_addr);
        end
        checks++;
        if (bus.store_pop !== 1'b0) begin
            failures++;
            $display("FAIL prio_slot_busy: got sp=%b, want 0", bus.store_pop);
        end
        bus.mem_ack = 1'b1;
        #1;
        checks++;
        if (bus.store_pop !== 1'b1) begin
            failures++;
            $display("FAIL prio_store_on_ack: got sp=%b, want 1", bus.store_pop);
        end
        tick();
        bus.store_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_rnw !== 1'b0 || bus.mem_addr !== 32'h0000_3000 ||
            bus.mem_be !== 4'h3 || bus.mem_wdata !== 32'hAABB_CCDD) begin
            failures++;
            $display("FAIL store_req: got req=%b rnw=%b addr=%h be=%h wdata=%h, want 1 0 00003000 3 aabbccdd",
                     bus.mem_req, bus.mem_rnw, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_id !== 3'd5 || bus.wb_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL lw_return: got v=%b id=%0d data=%h, want 1 5 12345678",
                     bus.wb_valid, bus.wb_id, bus.wb_data);
        end
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.ls_idle !== 1'b1) begin
            failures++;
            $display("FAIL wb_pulse: got v=%b idle=%b, want v=0 idle=1", bus.wb_valid, bus.ls_idle);
        end
    endtask

    task automatic test_extension();
        issue_load(32'h0000_1003, 3'b000, 3'd2);
        issue_load(32'h0000_1002, 3'b101, 3'd3);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h80FF_1234;
        tick();
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_id !== 3'd2 || bus.wb_data !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL ext_lb: got v=%b id=%0d data=%h, want 1 2 ffffff80",
                     bus.wb_valid, bus.wb_id, bus.wb_data);
        end
        tick();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_id !== 3'd3 || bus.wb_data !== 32'h0000_80FF) begin
            failures++;
            $display("FAIL ext_lhu: got v=%b id=%0d data=%h, want 1 3 000080ff",
                     bus.wb_valid, bus.wb_id, bus.wb_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.load_valid = 1'b1;
        bus.load_addr  = 32'h0000_4008;
        bus.load_fn3   = 3'b010;
        bus.load_id    = 3'd1;
        tick();
        bus.load_addr  = 32'h0000_5001;
        bus.load_fn3   = 3'b001;
        bus.load_id    = 3'd6;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_4008 || bus.mem_rnw !== 1'b1 ||
                bus.mem_be !== 4'hF || bus.load_pop !== 1'b0 || bus.store_pop !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got req=%b addr=%h rnw=%b be=%h lp=%b sp=%b, want 1 00004008 1 f 0 0",
                         c, bus.mem_req, bus.mem_addr, bus.mem_rnw, bus.mem_be, bus.load_pop, bus.store_pop);
            end
            tick();
        end
        bus.mem_ack = 1'b1;
        #1;
        checks++;
        if (bus.load_pop !== 1'b1) begin
            failures++;
            $display("FAIL bp_ack_pop: got lp=%b, want 1", bus.load_pop);
        end
        tick();
        bus.load_valid = 1'b0;
        bus.mem_ack    = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_5000) begin
            failures++;
            $display("FAIL bp_next_req: got req=%b addr=%h, want 1 00005000", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        drain();
    endtask

    task automatic test_full();
        for (int k = 0; k < MAX; k++) issue_load(32'h0000_8000 + 32'(k * 5), 3'b000 + 3'(k % 2), ID_W'(k));
        bus.load_valid  = 1'b1;
        bus.load_addr   = 32'h0000_6000;
        bus.load_fn3    = 3'b010;
        bus.load_id     = 3'd4;
        bus.store_valid = 1'b1;
        bus.store_addr  = 32'h0000_7000;
        bus.store_be    = 4'hF;
        bus.store_data  = 32'h0000_0055;
        #1;
        checks++;
        if (bus.load_pop !== 1'b0 || bus.store_pop !== 1'b1 || bus.ls_idle !== 1'b0) begin
            failures++;
            $display("FAIL full_stall: got lp=%b sp=%b idle=%b, want 0 1 0", bus.load_pop, bus.store_pop, bus.ls_idle);
        end
        tick();
        bus.store_valid = 1'b0;
        bus.mem_ack     = 1'b1;
        #1;
        checks++;
        if (bus.load_pop !== 1'b0) begin
            failures++;
            $display("FAIL full_still: got lp=%b, want 0", bus.load_pop);
        end
        tick();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.load_pop !== 1'b0) begin
            failures++;
            $display("FAIL full_ret_cycle: got lp=%b, want 0", bus.load_pop);
        end
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        checks++;
        if (bus.load_pop !== 1'b1 || bus.wb_valid !== 1'b1 || bus.wb_id !== 3'd0 || bus.wb_data !== m_wb_data) begin
            failures++;
            $display("FAIL full_reenable: got lp=%b v=%b id=%0d data=%h, want 1 1 0 %h",
                     bus.load_pop, bus.wb_valid, bus.wb_id, bus.wb_data, m_wb_data);
        end
        tick();
        bus.load_valid = 1'b0;
        bus.mem_ack    = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        drain();
    endtask

    task automatic test_in_order();
        for (int k = 1; k <= 3; k++) issue_load(32'h0000_0100 + 32'(k * 4), 3'b010, ID_W'(k));
        bus.mem_rvalid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.mem_rdata = 32'(k) * 32'h0101_0101;
            tick();
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_id !== ID_W'(k) || bus.wb_data !== 32'(k) * 32'h0101_0101) begin
                failures++;
                $display("FAIL in_order[%0d]: got v=%b id=%0d data=%h, want 1 %0d %h",
                         k, bus.wb_valid, bus.wb_id, bus.wb_data, k, 32'(k) * 32'h0101_0101);
            end
        end
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.ls_idle !== 1'b1) begin
            failures++;
            $display("FAIL in_order_idle: got %b, want 1", bus.ls_idle);
        end
        tick();
    endtask

    task automatic test_reset_spurious();
        issue_load(32'h0000_0A00, 3'b010, 3'd6);
        issue_load(32'h0000_0A04, 3'b010, 3'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.ls_idle !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got req=%b idle=%b, want 0 1", bus.mem_req, bus.ls_idle);
        end
        apply_reset();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.ls_idle !== 1'b1) begin
            failures++;
            $display("FAIL spurious_return: got v=%b idle=%b, want 0 1", bus.wb_valid, bus.ls_idle);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.load_valid  = ($urandom_range(0, 99) < 50);
            bus.load_addr   = $urandom;
            bus.load_fn3    = 3'($urandom_range(0, 7));
            bus.load_id     = ID_W'($urandom);
            bus.store_valid = ($urandom_range(0, 99) < 40);
            bus.store_addr  = $urandom;
            bus.store_be    = 4'($urandom);
            bus.store_data  = $urandom;
            bus.mem_ack     = ($urandom_range(0, 99) < 60);
            bus.mem_rvalid  = (m_trk.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            bus.mem_rdata   = $urandom;
            #1;
            checks++;
            if (bus.load_pop !== exp_lp() || bus.store_pop !== exp_sp()) begin
                failures++;
                $display("FAIL rnd_pop[%0d]: got lp=%b sp=%b, want lp=%b sp=%b",
                         c, bus.load_pop, bus.store_pop, exp_lp(), exp_sp());
            end
            checks++;
            if (bus.mem_req !== m_slot_v ||
                (m_slot_v && (bus.mem_rnw !== m_slot.rnw || bus.mem_be !== m_slot.be ||
                              bus.mem_addr !== (m_slot.rnw ? (m_slot.addr & 32'hFFFF_FFFC) : m_slot.addr) ||
                              (!m_slot.rnw && bus.mem_wdata !== m_slot.wdata)))) begin
                failures++;
                $display("FAIL rnd_req[%0d]: got req=%b rnw=%b addr=%h be=%h wdata=%h, want req=%b rnw=%b addr=%h be=%h wdata=%h",
                         c, bus.mem_req, bus.mem_rnw, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                         m_slot_v, m_slot.rnw, m_slot.addr, m_slot.be, m_slot.wdata);
            end
            checks++;
            if (bus.wb_valid !== m_wb_v || (m_wb_v && (bus.wb_id !== m_wb_id || bus.wb_data !== m_wb_data))) begin
                failures++;
                $display("FAIL rnd_wb[%0d]: got v=%b id=%0d data=%h, want v=%b id=%0d data=%h",
                         c, bus.wb_valid, bus.wb_id, bus.wb_data, m_wb_v, m_wb_id, m_wb_data);
            end
            checks++;
            if (bus.ls_idle !== (!m_slot_v && m_rsv == 0)) begin
                failures++;
                $display("FAIL rnd_idle[%0d]: got %b, want %b", c, bus.ls_idle, (!m_slot_v && m_rsv == 0));
            end
            tick();
        end
        set_idle();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        drain();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_priority();
        test_extension();
        test_backpressure();
        test_full();
        test_in_order();
        test_reset_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
